// File: rtl/mont_mul_384.sv
// Radix-2 sequential Montgomery multiplier for the BLS12-381 base field.
// z = x*y*2^-384 mod M, fixed 385-cycle latency, valid/ready on both sides.
module mont_mul_384 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [383:0] x_mul,
  input  logic [383:0] y_mul,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [383:0] z_mul
);
  localparam int W = 384;
  localparam logic [W-1:0] M =
    384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOOP  = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state;
  logic [W-1:0] x_sh, y_r;
  logic [W+1:0] s, t_add, t_red, s_nxt;
  logic [8:0]   i;
  logic [2:0]   d_hi;
  logic [W-1:0] d_lo;

  // S < 2M and y < M keep every intermediate below 4M < 2^386.
  always_comb begin
    t_add = s + (x_sh[0] ? {2'b00, y_r} : {(W+2){1'b0}});
    t_red = t_add[0] ? t_add + {2'b00, M} : t_add;
    s_nxt = t_red >> 1;
    {d_hi, d_lo} = {1'b0, s} - {3'b000, M};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      z_mul     <= '0;
      x_sh      <= '0;
      y_r       <= '0;
      s         <= '0;
      i         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_sh     <= x_mul;
          y_r      <= y_mul;
          s        <= '0;
          i        <= '0;
          in_ready <= 1'b0;
          state    <= LOOP;
        end
        LOOP: begin
          s    <= s_nxt;
          x_sh <= x_sh >> 1;
          i    <= i + 9'd1;
          if (i == 9'd383) state <= FINAL;
        end
        FINAL: begin
          // With S < 2M a non-borrowing difference is < M, so its top bits are zero.
          z_mul     <= (d_hi == 3'b000) ? d_lo : s[W-1:0];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mont_mul_384.sv
// Bench for mont_mul_384: directed cases plus random reduced pairs against
// a wide-integer modular-arithmetic reference.
module tb_mont_mul_384;
  localparam logic [383:0] M =
    384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [383:0] x_mul, y_mul, z_mul;

  int nvec = 0;
  int nerr = 0;
  logic [767:0] mw, rinv, rmod, r2, inv2, one;

  always #5 clk = ~clk;

  mont_mul_384 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_mul(x_mul), .y_mul(y_mul), .out_valid(out_valid),
    .out_ready(out_ready), .z_mul(z_mul)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [383:0] mulmod(input logic [383:0] a, input logic [383:0] b);
    logic [767:0] p;
    p = ({384'b0, a} * {384'b0, b}) % mw;
    return p[383:0];
  endfunction

  function automatic logic [383:0] mont(input logic [383:0] a, input logic [383:0] b);
    return mulmod(mulmod(a, b), rinv[383:0]);
  endfunction

  function automatic logic [383:0] rnd_red();
    logic [383:0] r;
    r = '0;
    for (int k = 0; k < 12; k++) r = {r[351:0], 32'($urandom)};
    return r % M;
  endfunction

  // Accept one operation and wait for out_valid; lat = edges after acceptance.
  task automatic run_op(input logic [383:0] a, input logic [383:0] b,
                        output logic [383:0] z, output int lat);
    lat = 0;
    in_valid = 1'b1;
    x_mul = a;
    y_mul = b;
    tick;
    in_valid = 1'b0;
    x_mul = '1;
    y_mul = '1;
    for (int k = 1; k <= 1000; k++) begin
      tick;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    z = z_mul;
  endtask

  task automatic finish_xfer(input string tag);
    tick;
    chk(tag, {382'b0, out_valid, in_ready}, 384'd1);
  endtask

  initial begin
    logic [383:0] z, z0, a, b;
    int lat;
    bit seen;

    mw  = {384'b0, M};
    one = 768'd1;
    inv2 = (mw + one) >> 1;
    rinv = one;
    repeat (384) rinv = (rinv * inv2) % mw;
    rmod = (one << 384) % mw;
    r2   = (rmod * rmod) % mw;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x_mul = '0; y_mul = '0;
    tick; tick;
    rst_n = 1'b1;
    chk("reset_hs", {382'b0, in_ready, out_valid}, 384'd2);
    chk("reset_z", z_mul, '0);

    run_op('0, M - 384'd1, z, lat);
    chk("zero_z", z, '0);
    chk("zero_lat", 384'(lat), 384'd385);
    finish_xfer("zero_xfer");

    run_op(384'h1234_5678, rmod[383:0], z, lat);
    chk("ident_z", z, 384'h1234_5678);
    finish_xfer("ident_xfer");

    run_op(M - 384'd1, M - 384'd1, z, lat);
    chk("worst_z", z, mont(M - 384'd1, M - 384'd1));
    chk("worst_lt_m", {383'b0, z < M}, 384'd1);
    chk("worst_lat", 384'(lat), 384'd385);
    finish_xfer("worst_xfer");

    run_op(M - 384'd2, r2[383:0], z, lat);
    chk("to_mont_z", z, mulmod(M - 384'd2, rmod[383:0]));
    finish_xfer("to_mont_xfer");

    // Backpressure: result must hold and new operands must be ignored.
    out_ready = 1'b0;
    a = rnd_red();
    b = rnd_red();
    run_op(a, b, z, lat);
    chk("bp_z", z, mont(a, b));
    z0 = z;
    for (int k = 0; k < 50; k++) begin
      in_valid = (k >= 10 && k < 14);
      x_mul = 384'd7;
      y_mul = 384'd9;
      tick;
      chk("bp_hs", {382'b0, out_valid, in_ready}, 384'd2);
      chk("bp_hold", z_mul, z0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    finish_xfer("bp_release");
    tick;
    chk("bp_single", {382'b0, out_valid, in_ready}, 384'd1);

    // Reset during iteration 200 of a 3*5 operation.
    in_valid = 1'b1;
    x_mul = 384'd3;
    y_mul = 384'd5;
    tick;
    in_valid = 1'b0;
    repeat (200) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rst_mid_hs", {382'b0, in_ready, out_valid}, 384'd2);
    chk("rst_mid_z", z_mul, '0);
    seen = 1'b0;
    repeat (400) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_no_stale", {383'b0, seen}, '0);
    run_op(384'd3, 384'd5, z, lat);
    chk("rst_after_z", z, mont(384'd3, 384'd5));
    chk("rst_after_lat", 384'(lat), 384'd385);
    finish_xfer("rst_after_xfer");

    for (int n = 0; n < 120; n++) begin
      a = rnd_red();
      b = rnd_red();
      run_op(a, b, z, lat);
      chk("rand_z", z, mont(a, b));
      chk("rand_lat", 384'(lat), 384'd385);
      finish_xfer("rand_xfer");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
